// File: rtl/dm_port_arbiter.sv
// rtl/dm_port_arbiter.sv - data-memory port arbiter between CPU MEM stage and DMA master
//
// Grants one word transaction per cycle on the data-memory port. The CPU wins
// contention unless DMA has been starved for STARVE_LIMIT cycles or holds the
// port through a locked burst of at most MAX_BURST grants.
//
// Optional feature: define DM_ARB_STATS_EN to build the stall/grant counters.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   cpu_req/kill/addr/we/wdata  MEM-stage access request (kill masks req)
//   cpu_rdata, cpu_stall        read word to MEM stage, pipeline freeze
//   dma_req/lock/addr/we/wdata  DMA access request, lock holds the port
//   dma_gnt, dma_rdata          DMA accepted this cycle, read word to DMA
//   mem_addr/we/wdata/rdata     DM bridge side (rdata is combinational)
//   stat_cpu_stall/dma_gnt      event counters (0 unless DM_ARB_STATS_EN)

module dm_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_BURST    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_kill,
  input  logic [29:0] cpu_addr,
  input  logic [3:0]  cpu_we,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_lock,
  input  logic [29:0] dma_addr,
  input  logic [3:0]  dma_we,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic [31:0] dma_rdata,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] stat_cpu_stall,
  output logic [31:0] stat_dma_gnt
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  typedef enum logic [1:0] {S_CPU, S_DMA, S_BURST} state_t;

  state_t     state, state_next;
  logic [3:0] starve_cnt, starve_next;
  logic [3:0] burst_cnt, burst_next;
  logic       creq;
  logic       cpu_gnt;

  assign creq = cpu_req & ~cpu_kill;

  // No grant while reset is high, so a burst cut by reset never commits a
  // write on the cycle that reset is sampled.
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (!reset) begin
      if (creq && dma_req) begin
        if (state == S_CPU) cpu_gnt = 1'b1;
        else                dma_gnt = 1'b1;
      end else begin
        cpu_gnt = creq;
        dma_gnt = dma_req;
      end
    end
  end

  assign cpu_stall = creq & ~cpu_gnt;
  assign cpu_rdata = cpu_gnt ? mem_rdata : 32'd0;
  assign dma_rdata = dma_gnt ? mem_rdata : 32'd0;

  always_comb begin
    mem_addr  = 30'd0;
    mem_we    = 4'd0;
    mem_wdata = 32'd0;
    if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_we    = cpu_we;
      mem_wdata = cpu_wdata;
    end else if (dma_gnt) begin
      mem_addr  = dma_addr;
      mem_we    = dma_we;
      mem_wdata = dma_wdata;
    end
  end

  always_comb begin
    state_next  = state;
    starve_next = starve_cnt;
    burst_next  = burst_cnt;
    if (dma_gnt && dma_lock && (burst_cnt < BURST_LAST)) begin
      state_next  = S_BURST;
      burst_next  = burst_cnt + 4'd1;
      starve_next = 4'd0;
    end else if (dma_gnt) begin
      // Unlocked grant or burst cap reached: a waiting CPU wins next cycle.
      state_next  = S_CPU;
      burst_next  = 4'd0;
      starve_next = 4'd0;
    end else if ((state == S_BURST) && !dma_req) begin
      state_next = S_CPU;
      burst_next = 4'd0;
    end else if (dma_req) begin
      if (starve_cnt < STARVE_MAX) starve_next = starve_cnt + 4'd1;
      if (starve_next >= STARVE_MAX) state_next = S_DMA;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_CPU;
      starve_cnt <= 4'd0;
      burst_cnt  <= 4'd0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_next;
      burst_cnt  <= burst_next;
    end
  end

`ifdef DM_ARB_STATS_EN
  logic [31:0] stall_total, gnt_total;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_total <= 32'd0;
      gnt_total   <= 32'd0;
    end else begin
      if (cpu_stall) stall_total <= stall_total + 32'd1;
      if (dma_gnt)   gnt_total   <= gnt_total + 32'd1;
    end
  end

  assign stat_cpu_stall = stall_total;
  assign stat_dma_gnt   = gnt_total;
`else
  assign stat_cpu_stall = 32'd0;
  assign stat_dma_gnt   = 32'd0;
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb/tb_dm_port_arbiter.sv - self-checking bench for dm_port_arbiter
module tb_dm_port_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam int MAX_BURST    = 8;
`ifdef DM_ARB_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_kill, dma_req, dma_lock;
  logic [29:0] cpu_addr, dma_addr, mem_addr;
  logic [3:0]  cpu_we, dma_we, mem_we;
  logic [31:0] cpu_wdata, dma_wdata, mem_wdata, mem_rdata;
  logic [31:0] cpu_rdata, dma_rdata, stat_cpu_stall, stat_dma_gnt;
  logic        cpu_stall, dma_gnt;

  always #5 clk = ~clk;

  dm_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_kill(cpu_kill), .cpu_addr(cpu_addr), .cpu_we(cpu_we),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_lock(dma_lock), .dma_addr(dma_addr), .dma_we(dma_we),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stat_cpu_stall(stat_cpu_stall), .stat_dma_gnt(stat_dma_gnt)
  );

  // Data-memory stub: combinational read, byte-lane write at posedge.
  logic [31:0] mem [0:255];
  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge clk)
    for (int b = 0; b < 4; b++)
      if (mem_we[b]) mem[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];

  int checks = 0;
  int errors = 0;

  // Reference model: consecutive denied-DMA count and length of the current
  // locked run of DMA grants; DMA wins contention when either is "owed".
  int          m_starve = 0;
  int          m_run = 0;
  logic [31:0] m_nstall = 0;
  logic [31:0] m_ndgnt = 0;
  logic        e_cpu_g, e_dma_g, e_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_eval();
    logic creq, dma_owed;
    creq     = cpu_req && !cpu_kill;
    dma_owed = (m_starve >= STARVE_LIMIT) || (m_run > 0);
    if (reset) begin
      e_cpu_g = 1'b0; e_dma_g = 1'b0;
    end else if (creq && dma_req) begin
      e_cpu_g = !dma_owed; e_dma_g = dma_owed;
    end else begin
      e_cpu_g = creq; e_dma_g = dma_req;
    end
    e_stall = creq && !e_cpu_g;
  endtask

  task automatic model_step();
    if (reset) begin
      m_starve = 0; m_run = 0; m_nstall = 0; m_ndgnt = 0;
    end else begin
      if (e_stall) m_nstall++;
      if (e_dma_g) m_ndgnt++;
      if (e_dma_g) begin
        m_run    = (dma_lock && (m_run + 1 < MAX_BURST)) ? m_run + 1 : 0;
        m_starve = 0;
      end else if ((m_run > 0) && !dma_req) begin
        m_run = 0;
      end else if (dma_req) begin
        if (m_starve < STARVE_LIMIT) m_starve++;
      end
    end
  endtask

  // Wait to the negedge and compare every output against the model.
  task automatic settle();
    logic [29:0] ea;
    logic [3:0]  ew;
    logic [31:0] ed, er;
    @(negedge clk);
    model_eval();
    ea = e_cpu_g ? cpu_addr  : e_dma_g ? dma_addr  : 30'd0;
    ew = e_cpu_g ? cpu_we    : e_dma_g ? dma_we    : 4'd0;
    ed = e_cpu_g ? cpu_wdata : e_dma_g ? dma_wdata : 32'd0;
    er = mem[ea[7:0]];
    chk("cpu_stall", 32'(cpu_stall), 32'(e_stall));
    chk("dma_gnt",   32'(dma_gnt),   32'(e_dma_g));
    chk("mem_addr",  32'(mem_addr),  32'(ea));
    chk("mem_we",    32'(mem_we),    32'(ew));
    chk("mem_wdata", mem_wdata, ed);
    chk("cpu_rdata", cpu_rdata, e_cpu_g ? er : 32'd0);
    chk("dma_rdata", dma_rdata, e_dma_g ? er : 32'd0);
    chk("stat_cpu_stall", stat_cpu_stall, STATS_ON ? m_nstall : 32'd0);
    chk("stat_dma_gnt",   stat_dma_gnt,   STATS_ON ? m_ndgnt  : 32'd0);
  endtask

  task automatic adv();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic inputs_low();
    cpu_req = 0; cpu_kill = 0; cpu_addr = 0; cpu_we = 0; cpu_wdata = 0;
    dma_req = 0; dma_lock = 0; dma_addr = 0; dma_we = 0; dma_wdata = 0;
  endtask

  task automatic do_reset();
    inputs_low();
    reset = 1;
    settle();
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    adv();
    reset = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    inputs_low();
    reset = 1;
    @(posedge clk);
    #1;
    do_reset();

    // CPU alone: store then load back.
    cpu_req = 1; cpu_we = 4'hF; cpu_addr = 30'h0C00; cpu_wdata = 32'h1234_5678;
    settle();
    chk("st_mem_we", 32'(mem_we), 32'hF);
    chk("st_stall",  32'(cpu_stall), 32'd0);
    adv();
    cpu_we = 4'h0;
    settle();
    chk("ld_rdata", cpu_rdata, 32'h1234_5678);
    adv();

    // Contention with no lock: DMA wins every fifth cycle.
    cpu_req = 1; cpu_we = 0; cpu_addr = 30'h0C00;
    dma_req = 1; dma_lock = 0; dma_addr = 30'h0010; dma_we = 0;
    for (int i = 0; i < 10; i++) begin
      settle();
      chk("cont_dma_gnt",   32'(dma_gnt),   32'(i == 4 || i == 9));
      chk("cont_cpu_stall", 32'(cpu_stall), 32'(i == 4 || i == 9));
      adv();
    end
    inputs_low();
    settle();
    chk("stat_dma_gnt_10",   stat_dma_gnt,   STATS_ON ? 32'd2 : 32'd0);
    chk("stat_cpu_stall_10", stat_cpu_stall, STATS_ON ? 32'd2 : 32'd0);
    adv();

    // Locked burst reaches the cap, then the waiting CPU wins.
    do_reset();
    cpu_req = 1; cpu_addr = 30'h0001;
    dma_req = 1; dma_lock = 1; dma_addr = 30'h0020; dma_we = 4'hF; dma_wdata = $urandom;
    for (int i = 0; i < 13; i++) begin
      settle();
      chk("burst_dma_gnt", 32'(dma_gnt),   32'(i >= 4 && i <= 11));
      chk("burst_stall",   32'(cpu_stall), 32'(i >= 4 && i <= 11));
      adv();
    end

    // Burst ends early when dma_req drops after three locked grants.
    do_reset();
    cpu_req = 1; dma_we = 0;
    for (int i = 0; i < 9; i++) begin
      dma_req  = (i != 7);
      dma_lock = (i < 7);
      settle();
      chk("early_dma_gnt", 32'(dma_gnt),   32'(i >= 4 && i <= 6));
      chk("early_stall",   32'(cpu_stall), 32'(i >= 4 && i <= 6));
      adv();
    end

    // Kill while stalled by a burst: stall drops, CPU store never reaches memory.
    do_reset();
    cpu_req = 1; cpu_we = 4'hF; cpu_wdata = 32'hDEAD_BEEF;
    dma_req = 1; dma_lock = 1; dma_we = 4'h0;
    for (int i = 0; i < 6; i++) begin
      cpu_kill = (i == 5);
      settle();
      if (i == 4) chk("kill_pre_stall", 32'(cpu_stall), 32'd1);
      if (i == 5) begin
        chk("kill_stall",  32'(cpu_stall), 32'd0);
        chk("kill_mem_we", 32'(mem_we),    32'd0);
        chk("kill_dma",    32'(dma_gnt),   32'd1);
      end
      adv();
    end

    // Reset in the middle of the burst: no write that cycle, CPU wins afterwards.
    cpu_kill = 0; dma_we = 4'hF; reset = 1;
    settle();
    chk("rstb_mem_we", 32'(mem_we),  32'd0);
    chk("rstb_dma",    32'(dma_gnt), 32'd0);
    adv();
    reset = 0;
    settle();
    chk("post_rst_dma",   32'(dma_gnt),   32'd0);
    chk("post_rst_stall", 32'(cpu_stall), 32'd0);
    adv();

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 63) == 0);
      cpu_req   = ($urandom_range(0, 3) != 0);
      cpu_kill  = ($urandom_range(0, 7) == 0);
      cpu_addr  = 30'($urandom);
      cpu_we    = 4'($urandom);
      cpu_wdata = $urandom;
      dma_req   = ($urandom_range(0, 2) != 0);
      dma_lock  = ($urandom_range(0, 3) != 0);
      dma_addr  = 30'($urandom);
      dma_we    = 4'($urandom);
      dma_wdata = $urandom;
      settle();
      adv();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
